// File: rtl/img_window_loader.sv
// Purpose: walks a 5x5 stride-1 window over an image held in a synchronous
//          memory and loads each window (full 25 pixels, or the new right-hand
//          column of 5) into the PU window buffer.
// Latency: a read issued in cycle n is written to the buffer in cycle n+1.
//          A full load takes 26 cycles and a column load takes 6 cycles, each
//          measured from FETCH entry to WAIT_ACK.
// Backpressure: after each window the loader stalls in WAIT_ACK until win_ack.
module img_window_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32,
  parameter int IMG_ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  img_rd_en,
  output logic [IMG_ADDR_W-1:0] img_rd_addr,
  input  logic [DATA_WIDTH-1:0] img_rd_data,
  output logic                  wr_ctrl_g,
  output logic [4:0]            adrs_in1,
  output logic [DATA_WIDTH-1:0] data_g,
  output logic [5:0]            round,
  input  logic                  win_ack,
  output logic                  busy,
  output logic                  frame_done
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT_ACK} state_t;

  localparam int AW1 = IMG_ADDR_W + 1;
  localparam logic [5:0] WC_LAST = 6'(IMG_W - 5);
  localparam logic [9:0] WR_LAST = 10'(IMG_H - 5);

  state_t     state;
  logic [9:0] wr;    // window row
  logic [5:0] wc;    // window column
  logic [2:0] rr;    // pixel row (within the window) of the read in flight
  logic [2:0] cc;    // pixel column (within the window) of the read in flight; full loads only
  logic [4:0] tgt;   // buffer slot of the read in flight

  // Linear pixel address, computed one bit wider than the memory port and then truncated.
  function automatic logic [IMG_ADDR_W-1:0] pix_addr(input logic [9:0] row, input logic [6:0] col);
    logic [IMG_ADDR_W:0] a;
    a = AW1'(row) * AW1'(IMG_W) + AW1'(col);
    return a[IMG_ADDR_W-1:0];
  endfunction

  // The buffer write data is the memory response, gated so that it is zero whenever no write is active.
  assign data_g = wr_ctrl_g ? img_rd_data : '0;

  // Window sequencer: read issue, the delayed write strobe and address, and the frame handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wr          <= '0;
      wc          <= '0;
      rr          <= '0;
      cc          <= '0;
      tgt         <= '0;
      img_rd_en   <= 1'b0;
      img_rd_addr <= '0;
      wr_ctrl_g   <= 1'b0;
      adrs_in1    <= '0;
      round       <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      wr_ctrl_g  <= img_rd_en;
      adrs_in1   <= tgt;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= FETCH;
            busy        <= 1'b1;
            wr          <= '0;
            wc          <= '0;
            round       <= '0;
            rr          <= '0;
            cc          <= '0;
            tgt         <= 5'd0;
            img_rd_en   <= 1'b1;
            img_rd_addr <= pix_addr(10'd0, 7'd0);
          end
        end
        FETCH: begin
          if (img_rd_en) begin
            if (tgt == 5'd24) begin
              img_rd_en <= 1'b0;
            end else begin
              tgt <= tgt + 5'd1;
              if (wc == '0 && cc != 3'd4) begin
                // Full load: step along the current pixel row.
                cc          <= cc + 3'd1;
                img_rd_addr <= pix_addr(wr + 10'(rr), 7'(cc) + 7'd1);
              end else begin
                // Move to the next pixel row; a column load always reads the rightmost column.
                rr          <= rr + 3'd1;
                cc          <= '0;
                img_rd_addr <= pix_addr(wr + 10'(rr) + 10'd1, (wc == '0) ? 7'd0 : 7'(wc) + 7'd4);
              end
            end
          end else if (wr_ctrl_g && adrs_in1 == 5'd24) begin
            state <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (win_ack) begin
            rr <= '0;
            cc <= '0;
            if (wc != WC_LAST) begin
              // Slide one column right: only the new right-hand column is loaded.
              state       <= FETCH;
              wc          <= wc + 6'd1;
              round       <= wc + 6'd1;
              tgt         <= 5'd20;
              img_rd_en   <= 1'b1;
              img_rd_addr <= pix_addr(wr, 7'(wc) + 7'd5);
            end else if (wr != WR_LAST) begin
              // Start the next window row with a full reload.
              state       <= FETCH;
              wr          <= wr + 10'd1;
              wc          <= '0;
              round       <= '0;
              tgt         <= 5'd0;
              img_rd_en   <= 1'b1;
              img_rd_addr <= pix_addr(wr + 10'd1, 7'd0);
            end else begin
              state      <= IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              wr         <= '0;
              wc         <= '0;
              round      <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
